// File: rtl/bus_arbiter_if.sv
// Signal bundle between the pipeline requesters, the arbiter and the Wishbone-style memory port.
// modport master: arbiter view (it masters the memory bus and answers the requesters).
// modport slave:  environment view (requesters plus memory slave).
interface bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Fetch requester
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          i_err;
    // Data requester
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_sel;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          d_err;
    // Pipeline control
    logic          flush;
    logic          stallreq_if;
    logic          stallreq_mem;
    // Memory bus
    logic          m_cyc_o;
    logic          m_stb_o;
    logic          m_we_o;
    logic [3:0]    m_sel_o;
    logic [AW-1:0] m_adr_o;
    logic [DW-1:0] m_dat_o;
    logic [DW-1:0] m_dat_i;
    logic          m_ack_i;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, flush, m_dat_i, m_ack_i,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, stallreq_if, stallreq_mem,
               m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, flush, m_dat_i, m_ack_i,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, stallreq_if, stallreq_mem,
               m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter: shares one Wishbone-style port between fetch and data requesters.
// Optional macro ROUND_ROBIN_EN: alternate grants on contention instead of data-over-fetch.
module bus_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.master bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;   // 0 = fetch, 1 = data
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_cyc, w_cyc_nxt;
    logic          r_we, w_we_nxt;
    logic [3:0]    r_sel, w_sel_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic [DW-1:0] r_dat, w_dat_nxt;
    logic [DW-1:0] r_i_rdata, w_i_rdata_nxt;
    logic [DW-1:0] r_d_rdata, w_d_rdata_nxt;
    logic          r_i_ack, w_i_ack_nxt;
    logic          r_i_err, w_i_err_nxt;
    logic          r_d_ack, w_d_ack_nxt;
    logic          r_d_err, w_d_err_nxt;
`ifdef ROUND_ROBIN_EN
    logic          r_last, w_last_nxt;     // last grant: 0 = fetch, 1 = data
`endif

    logic          w_i_req;
    logic          w_d_req;
    logic          w_grant_d;
    logic          w_timeout;
    logic [CW-1:0] w_cnt_inc;

    // Next-state, bus attribute and response logic
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_cyc_nxt     = r_cyc;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_i_rdata_nxt = r_i_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_i_ack_nxt   = 1'b0;
        w_i_err_nxt   = 1'b0;
        w_d_ack_nxt   = 1'b0;
        w_d_err_nxt   = 1'b0;
`ifdef ROUND_ROBIN_EN
        w_last_nxt    = r_last;
`endif
        // A requester still holding req during its own response pulse is not re-granted.
        w_i_req = bus.i_req & ~r_i_ack & ~r_i_err;
        w_d_req = bus.d_req & ~r_d_ack & ~r_d_err;
`ifdef ROUND_ROBIN_EN
        w_grant_d = w_d_req & (~w_i_req | ~r_last);
`else
        w_grant_d = w_d_req;
`endif
        w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        w_cnt_inc = (r_cnt == CW'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + CW'(1);

        unique case (r_state)
            StIdle: begin
                if (!bus.flush && (w_i_req || w_d_req)) begin
                    w_state_nxt = StBusy;
                    w_owner_nxt = w_grant_d;
                    w_cnt_nxt   = '0;
                    w_cyc_nxt   = 1'b1;
`ifdef ROUND_ROBIN_EN
                    w_last_nxt  = w_grant_d;
`endif
                    if (w_grant_d) begin
                        w_we_nxt  = bus.d_we;
                        w_sel_nxt = bus.d_sel;
                        w_adr_nxt = bus.d_addr;
                        w_dat_nxt = bus.d_wdata;
                    end else begin
                        w_we_nxt  = 1'b0;
                        w_sel_nxt = 4'hF;
                        w_adr_nxt = bus.i_addr;
                        w_dat_nxt = '0;
                    end
                end
            end
            StBusy: begin
                if (bus.m_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = StIdle;
                    if (!bus.flush) begin
                        if (r_owner) begin
                            w_d_ack_nxt   = 1'b1;
                            w_d_rdata_nxt = bus.m_dat_i;
                        end else begin
                            w_i_ack_nxt   = 1'b1;
                            w_i_rdata_nxt = bus.m_dat_i;
                        end
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_timeout) begin
                        w_cyc_nxt   = 1'b0;
                        w_state_nxt = StIdle;
                        // A flush in the same cycle discards the error too.
                        if (!bus.flush) begin
                            w_d_err_nxt = r_owner;
                            w_i_err_nxt = ~r_owner;
                        end
                    end else if (bus.flush) begin
                        w_state_nxt = StDrain;
                    end
                end
            end
            StDrain: begin
                if (bus.m_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_timeout) begin
                        w_cyc_nxt   = 1'b0;
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            r_last    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cyc     <= w_cyc_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_sel_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_i_rdata <= w_i_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_i_ack   <= w_i_ack_nxt;
            r_i_err   <= w_i_err_nxt;
            r_d_ack   <= w_d_ack_nxt;
            r_d_err   <= w_d_err_nxt;
`ifdef ROUND_ROBIN_EN
            r_last    <= w_last_nxt;
`endif
        end
    end

    assign bus.m_cyc_o      = r_cyc;
    assign bus.m_stb_o      = r_cyc;
    assign bus.m_we_o       = r_we;
    assign bus.m_sel_o      = r_sel;
    assign bus.m_adr_o      = r_adr;
    assign bus.m_dat_o      = r_dat;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.i_ack        = r_i_ack;
    assign bus.i_err        = r_i_err;
    assign bus.d_ack        = r_d_ack;
    assign bus.d_err        = r_d_err;
    assign bus.stallreq_if  = bus.i_req & ~r_i_ack & ~r_i_err;
    assign bus.stallreq_mem = bus.d_req & ~r_d_ack & ~r_d_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order, attributes and responses.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    bus_arbiter_if #(.AW(32), .DW(32)) bus ();

    bus_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of what the requesters presented and what the arbiter should have returned
    logic [31:0] i_addr_v;
    logic        d_we_v;
    logic [3:0]  d_sel_v;
    logic [31:0] d_addr_v;
    logic [31:0] d_wdata_v;
    logic [31:0] exp_i_rdata = 32'h0;
    logic [31:0] exp_d_rdata = 32'h0;
`ifdef ROUND_ROBIN_EN
    bit          last_was_d = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner when both are visible: data first, or alternate under round robin.
    function automatic bit pick(input bit ir, input bit dr);
`ifdef ROUND_ROBIN_EN
        if (ir && dr) return !last_was_d;
`endif
        return dr;
    endfunction

    task automatic set_i(input logic [31:0] a);
        i_addr_v   = a;
        bus.i_addr = a;
        bus.i_req  = 1'b1;
    endtask

    task automatic set_d(input logic we, input logic [3:0] sel, input logic [31:0] a,
                         input logic [31:0] wd);
        d_we_v      = we;
        d_sel_v     = sel;
        d_addr_v    = a;
        d_wdata_v   = wd;
        bus.d_we    = we;
        bus.d_sel   = sel;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
    endtask

    task automatic drop(input bit own_d);
        if (own_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
    endtask

    task automatic expect_grant(input bit own_d, input string tag);
        chk({tag, ".cyc"}, bus.m_cyc_o, 1);
        chk({tag, ".stb"}, bus.m_stb_o, 1);
        if (own_d) begin
            chk({tag, ".we"},    bus.m_we_o,       d_we_v);
            chk({tag, ".sel"},   bus.m_sel_o,      d_sel_v);
            chk({tag, ".adr"},   bus.m_adr_o,      d_addr_v);
            chk({tag, ".dat"},   bus.m_dat_o,      d_wdata_v);
            chk({tag, ".stall"}, bus.stallreq_mem, 1);
        end else begin
            chk({tag, ".we"},    bus.m_we_o,      0);
            chk({tag, ".sel"},   bus.m_sel_o,     4'hF);
            chk({tag, ".adr"},   bus.m_adr_o,     i_addr_v);
            chk({tag, ".stall"}, bus.stallreq_if, 1);
        end
`ifdef ROUND_ROBIN_EN
        last_was_d = own_d;
`endif
    endtask

    // Slave side: wait states, then ack with rd; owner attributes scrambled meanwhile.
    task automatic serve(input bit own_d, input int waits, input logic [31:0] rd);
        if (own_d) bus.d_addr = $urandom;
        else       bus.i_addr = $urandom;
        for (int j = 0; j < waits; j++) begin
            bus.m_ack_i = 1'b0;
            tick();
            chk("wait.cyc", bus.m_cyc_o, 1);
            chk("wait.adr", bus.m_adr_o, own_d ? d_addr_v : i_addr_v);
            chk("wait.stall", own_d ? bus.stallreq_mem : bus.stallreq_if, 1);
            chk("wait.ack", own_d ? bus.d_ack : bus.i_ack, 0);
        end
        bus.m_dat_i = rd;
        bus.m_ack_i = 1'b1;
        tick();
        bus.m_ack_i = 1'b0;
        bus.m_dat_i = $urandom;
        if (own_d) exp_d_rdata = rd;
        else       exp_i_rdata = rd;
        chk("resp.cyc",    bus.m_cyc_o, 0);
        chk("resp.i_ack",  bus.i_ack, !own_d);
        chk("resp.d_ack",  bus.d_ack, own_d);
        chk("resp.i_err",  bus.i_err, 0);
        chk("resp.d_err",  bus.d_err, 0);
        chk("resp.i_data", bus.i_rdata, exp_i_rdata);
        chk("resp.d_data", bus.d_rdata, exp_d_rdata);
        chk("resp.stall",  own_d ? bus.stallreq_mem : bus.stallreq_if, 0);
    endtask

    // One round: the requests already set up, served in model order.
    task automatic run(input bit ir, input bit dr, input int wi, input int wd);
        bit first;
        first = pick(ir, dr);
        tick();
        expect_grant(first, "grant1");
        serve(first, first ? wd : wi, $urandom);
        drop(first);
        if (ir && dr) begin
            tick();
            chk("grant2.prev_ack", first ? bus.d_ack : bus.i_ack, 0);
            expect_grant(!first, "grant2");
            serve(!first, first ? wi : wd, $urandom);
            drop(!first);
        end
        tick();
        chk("idle.cyc",   bus.m_cyc_o, 0);
        chk("idle.i_ack", bus.i_ack, 0);
        chk("idle.d_ack", bus.d_ack, 0);
    endtask

    initial begin
        bus.i_req   = 1'b1;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_sel   = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.flush   = 1'b0;
        bus.m_dat_i = '0;
        bus.m_ack_i = 1'b0;

        // Reset values; stall requests follow the inputs
        #12;
        chk("rst.cyc",      bus.m_cyc_o, 0);
        chk("rst.stb",      bus.m_stb_o, 0);
        chk("rst.we",       bus.m_we_o, 0);
        chk("rst.sel",      bus.m_sel_o, 0);
        chk("rst.adr",      bus.m_adr_o, 0);
        chk("rst.dat",      bus.m_dat_o, 0);
        chk("rst.acks",     {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 0);
        chk("rst.rdata",    {bus.i_rdata, bus.d_rdata}, 0);
        chk("rst.stall_if", bus.stallreq_if, 1);
        chk("rst.stall_mem", bus.stallreq_mem, 0);
        bus.i_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst.cyc", bus.m_cyc_o, 0);

        // Single fetch against a zero-wait slave; req held through the ack pulse
        set_i(32'h100);
        tick();
        expect_grant(1'b0, "fetch");
        serve(1'b0, 0, 32'hDEADBEEF);
        tick();
        chk("fetch.no_regrant", bus.m_cyc_o, 0);
        chk("fetch.one_pulse",  bus.i_ack, 0);
        drop(1'b0);
        tick();

        // Contention, repeated to expose alternation under round robin
        for (int r = 0; r < 3; r++) begin
            set_d(1'b1, 4'h3, 32'h200, 32'h55AA);
            set_i(32'h300 + 32'(r * 4));
            run(1'b1, 1'b1, 0, 1);
        end

        // Stall request against a 2-wait slave
        set_d(1'b0, 4'hF, 32'h240, 32'h0);
        run(1'b0, 1'b1, 0, 2);

        // Flush during BUSY: cycle held until the slave acks, response discarded
        set_d(1'b0, 4'hF, 32'h400, 32'h0);
        tick();
        expect_grant(1'b1, "flush");
        bus.flush = 1'b1;
        bus.d_req = 1'b0;
        tick();
        bus.flush = 1'b0;
        chk("flush.hold1", bus.m_cyc_o, 1);
        tick();
        chk("flush.hold2", bus.m_cyc_o, 1);
        bus.m_dat_i = 32'h12345678;
        bus.m_ack_i = 1'b1;
        tick();
        bus.m_ack_i = 1'b0;
        chk("flush.cyc_drop", bus.m_cyc_o, 0);
        chk("flush.no_ack",   bus.d_ack, 0);
        chk("flush.no_err",   bus.d_err, 0);
        chk("flush.rdata",    bus.d_rdata, exp_d_rdata);
        set_d(1'b1, 4'hC, 32'h404, 32'hCAFE0000);
        run(1'b0, 1'b1, 0, 0);

        // Timeout: the slave never acks
        set_d(1'b0, 4'hF, 32'h500, 32'h0);
        tick();
        expect_grant(1'b1, "tmo");
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("tmo.cyc_held", bus.m_cyc_o, 1);
            chk("tmo.no_err",   bus.d_err, 0);
        end
        tick();
        chk("tmo.cyc_drop", bus.m_cyc_o, 0);
        chk("tmo.err",      bus.d_err, 1);
        chk("tmo.no_ack",   bus.d_ack, 0);
        chk("tmo.stall",    bus.stallreq_mem, 0);
        drop(1'b1);
        tick();
        chk("tmo.err_once", bus.d_err, 0);
        set_d(1'b0, 4'hF, 32'h504, 32'h0);
        run(1'b0, 1'b1, 0, 1);

        // Asynchronous reset in the middle of a bus cycle
        set_i(32'h600);
        tick();
        expect_grant(1'b0, "arst");
        #2;
        rst = 1'b0;
        #1;
        chk("arst.cyc",   bus.m_cyc_o, 0);
        chk("arst.acks",  {bus.i_ack, bus.d_ack}, 0);
        chk("arst.rdata", bus.i_rdata, 0);
        exp_i_rdata = '0;
        exp_d_rdata = '0;
`ifdef ROUND_ROBIN_EN
        last_was_d = 1'b0;
`endif
        drop(1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst.idle", bus.m_cyc_o, 0);
        set_i(32'h604);
        run(1'b1, 1'b0, 1, 0);

        // Randomized traffic checked against the model
        for (int n = 0; n < 12; n++) begin
            int mode;
            bit ir;
            bit dr;
            mode = int'($urandom_range(1, 3));
            ir   = (mode != 2);
            dr   = (mode != 1);
            if (ir) set_i($urandom & 32'hFFFF_FFFC);
            if (dr) set_d(1'($urandom), 4'($urandom), $urandom, $urandom);
            run(ir, dr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
